// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor step per clock, LSB first,
// with parallel load, parallel result and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_ai   = r_a[0];
    assign w_bi   = r_b[0];
    assign w_d    = w_ai ^ w_bi ^ r_borrow;
    assign w_bo   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Result fills from the MSB end so the first (LSB) step lands in bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_one
            assign w_res_next = w_d;
        end else begin : g_wide
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    r_res    <= w_res_next;
                    r_borrow <= w_bo;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Outputs update only here, so partial results never reach diff.
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: 8-bit and 1-bit instances checked
// against plain-arithmetic subtraction.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       bin8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_d = '0;
    logic       prev_b = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_diff(input int x, input int y, input int z, input int w);
        return 8'((x - y - z) % (1 << w));
    endfunction

    function automatic logic ref_bout(input int x, input int y, input int z);
        return x < (y + z);
    endfunction

    // One 8-bit operation; optionally scrambles inputs during SHIFT or pulses start mid-op.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input bit scramble, input bit pulse);
        logic [7:0] ed;
        logic       eb;
        ed = ref_diff(int'(ta), int'(tb), int'(tbin), 8);
        eb = ref_bout(int'(ta), int'(tb), int'(tbin));
        @(negedge clk);
        a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_e0", 32'(busy8), 32'd1);
        chk("done_e0", 32'(done8), 32'd0);
        for (int k = 1; k < 8; k++) begin
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            start8 = pulse && (k == 3);
            @(posedge clk); #1;
            chk("busy_step", 32'(busy8), 32'd1);
            chk("done_step", 32'(done8), 32'd0);
            chk("diff_hold", 32'(diff8), 32'(prev_d));
            chk("bout_hold", 32'(bout8), 32'(prev_b));
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 32'(done8), 32'd1);
        chk("busy_done", 32'(busy8), 32'd0);
        chk("diff", 32'(diff8), 32'(ed));
        chk("bout", 32'(bout8), 32'(eb));
        @(posedge clk); #1;
        chk("done_low", 32'(done8), 32'd0);
        chk("busy_idle", 32'(busy8), 32'd0);
        chk("diff_idle", 32'(diff8), 32'(ed));
        prev_d = ed;
        prev_b = eb;
    endtask

    task automatic run1(input logic ta, input logic tb, input logic tbin);
        @(negedge clk);
        a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("w1_busy", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        chk("w1_done", 32'(done1), 32'd1);
        chk("w1_diff", 32'(diff1), 32'(ref_diff(int'(ta), int'(tb), int'(tbin), 1) & 8'h01));
        chk("w1_bout", 32'(bout1), 32'(ref_bout(int'(ta), int'(tb), int'(tbin))));
        @(posedge clk); #1;
        chk("w1_done_low", 32'(done1), 32'd0);
    endtask

    initial begin
        int         ndone;
        logic [7:0] ra, rb;
        logic       rbin;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h35, 8'h12, 1'b0, 1'b0, 1'b0);
        run8(8'h12, 8'h35, 1'b0, 1'b0, 1'b0);
        run8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        run8(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b1);
        run8(8'h01, 8'hC3, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run1(v[2], v[1], v[0]);
        end

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            run8(ra, rb, rbin, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // start held high: back-to-back accepts every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h9C; b8 = 8'h47; bin8 = 1'b1; start8 = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        start8 = 1'b0;
        chk("held_done_count", 32'(ndone), 32'd2);
        chk("held_diff", 32'(diff8), 32'(ref_diff(32'h9C, 32'h47, 1, 8)));
        prev_d = ref_diff(32'h9C, 32'h47, 1, 8);
        prev_b = ref_bout(32'h9C, 32'h47, 1);
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset mid-operation
        @(negedge clk);
        a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_diff", 32'(diff8), 32'd0);
        chk("arst_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        prev_d = '0;
        prev_b = 1'b0;
        run8(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing a - b - bin. It uses one full-subtractor bit cell per clock, with the borrow held in a flip-flop between bits. It is the sequential consumer stage for the team's combinational full-subtractor cell, replacing a WIDTH-wide ripple array when area matters. Operands load in parallel and results present in parallel, with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are 1 or greater.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; sampled on the accepting edge.
b  input  WIDTH  subtrahend; sampled on the accepting edge.
bin  input  1  borrow-in; sampled on the accepting edge.
busy  output  1  high while bit steps are in progress.
done  output  1  one-cycle pulse when the result becomes valid.
diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset: rst=1 forces state IDLE immediately, regardless of clock. All of the following clear to 0: busy, done, diff, bout, borrow flop, bit counter, operand shift registers.
- State IDLE: busy=0, done=0.
  - start=1 at a rising edge: load a and b into shift registers and bin into the borrow flop; clear the counter; go to SHIFT. busy=1 from this edge.
  - start=0: remain in IDLE.
- State SHIFT, one bit step per edge, LSB first:
  - ai = shift_a[0], bi = shift_b[0], br = borrow flop.
  - d = ai ^ bi ^ br.
  - bo = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift d into the result register from the MSB end.
  - borrow flop <= bo.
  - Shift both operand registers right by one.
  - counter++.
  - On the step where counter = WIDTH-1:
    - diff <= the complete result including this bit.
    - bout <= bo.
    - Go to DONE.
- State DONE: done=1 and busy=0 for exactly one cycle. The next edge goes unconditionally to IDLE.
- Latency: done is visible after edge E0+WIDTH, where E0 is the edge that sampled start. It is low again after E0+WIDTH+1. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Output stability: diff and bout change only at the final step edge. They hold their value through DONE, IDLE and the whole of the next operation, until that operation's final step. Intermediate bits never appear on diff.
- Handshake edge cases:
  - start while in SHIFT or DONE: ignored; no queueing.
  - a, b and bin may change freely after E0 without affecting the operation in progress.
  - start held high continuously: a new operation is accepted each time the block is in IDLE.
- Reset mid-operation: the operation is aborted and outputs clear to 0. No done pulse is produced. The next start after rst falls operates normally.
- WIDTH=1: a single SHIFT cycle; done appears after E0+1.
- Counter width is clog2(WIDTH) bits, minimum 1, and must not wrap before WIDTH-1.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0 -> after 8 edges: done pulse, diff=0x23, bout=0; busy high for exactly 8 cycles.
- WIDTH=8, a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- WIDTH=1, all 8 (a, b, bin) combinations -> diff/bout match the full-subtractor truth table:
  - d: 0,1,1,0,1,0,0,1.
  - bo: 0,1,1,1,0,0,0,1.
- Start pulsed on cycle 3 of a busy 8-bit operation with different operands -> ignored; the first result is correct; exactly one done pulse occurs.
- Operands changed every cycle during SHIFT -> result still reflects the values sampled at E0. diff stays at its previous result until the final edge.
- rst asserted asynchronously mid-cycle during step 4 -> busy, done, diff and bout read 0 before the next edge. No done pulse follows. A subsequent a=0x80, b=0x01, bin=0 operation -> diff=0x7F, bout=0.
